// File: rtl/top_pkg.sv
// Shared definitions for the instruction fetch/decode slice.
// Holds the program-counter width, RV32 opcode constants used for format
// selection, the NOP encoding, the ROM initial-contents table and a helper
// that returns the constant ROM word for any word index.
package top_pkg;

  localparam int unsigned PC_W = 8;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int unsigned ROM_INIT_LEN = 4;
  localparam logic [31:0] ROM_INIT [ROM_INIT_LEN] = '{
    32'h0051_0093,  // addi x1,x2,5
    32'h0020_81B3,  // add  x3,x1,x2
    32'h0030_A423,  // sw   x3,8(x1)
    32'hFFF0_2203   // lw   x4,-1(x0)
  };

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_OTHER
  } fmt_e;

  // Words beyond the init table read as NOP.
  function automatic logic [31:0] rom_word(input int unsigned idx);
    logic [31:0] w;
    w = NOP;
    for (int unsigned i = 0; i < ROM_INIT_LEN; i++) begin
      if (idx == i) w = ROM_INIT[i];
    end
    return w;
  endfunction

endpackage

// File: rtl/top_instr_mem.sv
// instr_mem: constant, combinational instruction ROM.
// Ports:
//   addr  in   word index into the ROM ($clog2(DEPTH) bits)
//   data  out  32-bit instruction word at addr (zero-latency read)
module instr_mem
  import top_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);

  always_comb begin
    data = NOP;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (addr == AW'(i)) data = rom_word(i);
    end
  end

endmodule

// File: rtl/top.sv
// top: byte program counter feeding a constant instruction ROM, with an
// RV32 field decoder on the fetched word.
// Ports:
//   clk  in   single clock, rising edge
//   rst  in   synchronous active-high reset (PC -> 0x00)
//   rd   out  destination register field (0 for S/B formats)
//   rs1  out  source register 1 field (0 for other formats)
//   rs2  out  source register 2 field (R/S/B only)
//   imm  out  12-bit immediate (I, S, B; B gives offset bits 12:1)
module top
  import top_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [11:0] imm
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [PC_W-1:0] pc;
  logic [31:0]     instr;
  fmt_e            fmt;

  // Byte PC steps by 4 and wraps naturally at the register width.
  always_ff @(posedge clk) begin
    if (rst) pc <= '0;
    else     pc <= pc + PC_W'(4);
  end

  instr_mem #(
    .DEPTH (MEM_DEPTH)
  ) u_instr_mem (
    .addr (pc[2 +: AW]),
    .data (instr)
  );

  always_comb begin
    case (instr[6:0])
      OP_R:                                   fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:    fmt = FMT_I;
      OP_STORE:                               fmt = FMT_S;
      OP_BRANCH:                              fmt = FMT_B;
      default:                                fmt = FMT_OTHER;
    endcase
  end

  always_comb begin
    rd  = '0;
    rs1 = '0;
    rs2 = '0;
    imm = '0;
    case (fmt)
      FMT_R: begin
        rd  = instr[11:7];
        rs1 = instr[19:15];
        rs2 = instr[24:20];
      end
      FMT_I: begin
        rd  = instr[11:7];
        rs1 = instr[19:15];
        imm = instr[31:20];
      end
      FMT_S: begin
        rs1 = instr[19:15];
        rs2 = instr[24:20];
        imm = {instr[31:25], instr[11:7]};
      end
      FMT_B: begin
        rs1 = instr[19:15];
        rs2 = instr[24:20];
        imm = {instr[31], instr[7], instr[30:25], instr[11:8]};
      end
      default: begin
        rd = instr[11:7];
      end
    endcase
  end

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: directed reset/sequence/wrap checks followed
// by a randomized run with sporadic resets, all compared against a
// behavioural model (integer PC plus field extraction by arithmetic).
module tb_top;

  logic        clk;
  logic        rst;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [11:0] imm;

  int checks = 0;
  int errors = 0;
  int mpc    = 0;  // model PC, byte address 0..255

  top #(
    .MEM_DEPTH (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rd  (rd),
    .rs1 (rs1),
    .rs2 (rs2),
    .imm (imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned model_word(input int pc);
    int idx;
    idx = pc / 4;
    case (idx)
      0:       return 32'h0051_0093;
      1:       return 32'h0020_81B3;
      2:       return 32'h0030_A423;
      3:       return 32'hFFF0_2203;
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic int unsigned fld(input int unsigned w, input int lo, input int n);
    return (w >> lo) % (32'd1 << n);
  endfunction

  task automatic model_fields(input int pc, output int unsigned erd, output int unsigned ers1,
                              output int unsigned ers2, output int unsigned eimm);
    int unsigned w, op;
    w    = model_word(pc);
    op   = fld(w, 0, 7);
    erd  = 0; ers1 = 0; ers2 = 0; eimm = 0;
    if (op == 'h33) begin
      erd = fld(w, 7, 5); ers1 = fld(w, 15, 5); ers2 = fld(w, 20, 5);
    end else if (op == 'h13 || op == 'h03 || op == 'h67 || op == 'h73) begin
      erd = fld(w, 7, 5); ers1 = fld(w, 15, 5); eimm = fld(w, 20, 12);
    end else if (op == 'h23) begin
      ers1 = fld(w, 15, 5); ers2 = fld(w, 20, 5);
      eimm = fld(w, 25, 7) * 32 + fld(w, 7, 5);
    end else if (op == 'h63) begin
      ers1 = fld(w, 15, 5); ers2 = fld(w, 20, 5);
      eimm = fld(w, 31, 1) * 2048 + fld(w, 7, 1) * 1024 + fld(w, 25, 6) * 16 + fld(w, 8, 4);
    end else begin
      erd = fld(w, 7, 5);
    end
  endtask

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (model pc %02h)", tag, got, exp, mpc[7:0]);
    end
  endtask

  task automatic chk_const(input string tag, input int unsigned erd, input int unsigned ers1,
                           input int unsigned ers2, input int unsigned eimm);
    chk({tag, ".rd"},  {7'd0, rd},  12'(erd));
    chk({tag, ".rs1"}, {7'd0, rs1}, 12'(ers1));
    chk({tag, ".rs2"}, {7'd0, rs2}, 12'(ers2));
    chk({tag, ".imm"}, imm,         12'(eimm));
  endtask

  task automatic chk_model(input string tag);
    int unsigned a, b, c, d;
    model_fields(mpc, a, b, c, d);
    chk_const(tag, a, b, c, d);
  endtask

  // Drive rst away from the edge, take one rising edge, settle on negedge.
  task automatic step(input logic r);
    rst = r;
    @(posedge clk);
    mpc = r ? 0 : (mpc + 4) % 256;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    step(1'b1);
    chk_const("reset_hold", 1, 2, 0, 'h005);
    step(1'b1);
    chk_const("reset_hold2", 1, 2, 0, 'h005);

    rst = 1'b0;
    chk_const("word0", 1, 2, 0, 'h005);
    step(1'b0); chk_const("word1", 3, 1, 2, 'h000);
    step(1'b0); chk_const("word2", 0, 1, 3, 'h008);
    step(1'b0); chk_const("word3", 4, 0, 0, 'hFFF);
    for (int i = 4; i < 64; i++) begin
      step(1'b0);
      chk_const("nop", 0, 0, 0, 0);
    end
    step(1'b0); chk_const("wrap_word0", 1, 2, 0, 'h005);
    step(1'b0); chk_const("wrap_word1", 3, 1, 2, 'h000);

    while (mpc != 'h28) step(1'b0);
    chk_const("pc28_nop", 0, 0, 0, 0);
    step(1'b1); chk_const("midreset_word0", 1, 2, 0, 'h005);
    step(1'b0); chk_const("midreset_word1", 3, 1, 2, 'h000);
    step(1'b0); chk_const("midreset_word2", 0, 1, 3, 'h008);
    step(1'b0); chk_const("midreset_word3", 4, 0, 0, 'hFFF);

    for (int i = 0; i < 100; i++) begin
      step(1'b0);
      chk_model("free");
    end

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 15) == 0);
      chk_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter MEM_DEPTH, default 64, number of 32-bit instruction words in the ROM (power of two).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 rd  output  5  destination-register field of the current instruction.
REQ-005 rs1  output  5  source-register-1 field of the current instruction.
REQ-006 rs2  output  5  source-register-2 field of the current instruction.
REQ-007 imm  output  12  12-bit immediate of the current instruction.

Function
REQ-008 The block SHALL hold an 8-bit byte program counter (PC); the ROM word index is PC[7:2] (MEM_DEPTH=64).
REQ-009 Each rising clk edge with rst low SHALL advance PC by 4, modulo 256 (0xFC -> 0x00, wrap-around with no stall).
REQ-010 ROM read SHALL be combinational: the current instruction is ROM[PC[7:2]] in the same cycle PC holds that value (zero latency from PC to outputs).
REQ-011 ROM contents SHALL be constant: word0=0x00510093 (addi x1,x2,5), word1=0x002081B3 (add x3,x1,x2), word2=0x0030A423 (sw x3,8(x1)), word3=0xFFF02203 (lw x4,-1(x0)), all other words=0x00000013 (nop).
REQ-012 Decode SHALL use opcode instr[6:0] to select the format: R=0110011, I=0010011/0000011/1100111/1110011, S=0100011, B=1100011; any other opcode is "other".
REQ-013 rd SHALL equal instr[11:7] for R, I and other formats; 0 for S and B.
REQ-014 rs1 SHALL equal instr[19:15] for R, I, S, B; 0 for other.
REQ-015 rs2 SHALL equal instr[24:20] for R, S, B; 0 for I and other.
REQ-016 imm SHALL be instr[31:20] for I; {instr[31:25],instr[11:7]} for S; {instr[31],instr[7],instr[30:25],instr[11:8]} for B (offset bits 12:1); 0 for R and other.
REQ-017 Outputs SHALL be purely combinational functions of PC; no output glitches matter beyond settling within the cycle.

Reset
REQ-018 rst high at a rising edge SHALL set PC to 0x00, overriding the increment (rst wins over simultaneous increment).
REQ-019 While rst is held high PC SHALL stay 0x00; outputs therefore show word0: rd=1, rs1=2, rs2=0, imm=0x005.
REQ-020 Reset asserted mid-run SHALL restart from word0 on the next edge; first increment occurs on the first edge with rst low.
REQ-021 Before the first reset PC is undefined; no behaviour is required until rst has been sampled high once.

Structure
REQ-022 A shared package SHALL hold opcode constants, the NOP constant, PC width (8) and the ROM init table.
REQ-023 One sub-module instr_mem (combinational ROM, word-index in, 32-bit instruction out) SHALL be used; PC register and field decode live in top.

Verification
REQ-024 rst=1 for one edge, release -> cycle0: rd=1, rs1=2, rs2=0, imm=0x005.
REQ-025 Next edge -> word1: rd=3, rs1=1, rs2=2, imm=0x000; next -> word2: rd=0, rs1=1, rs2=3, imm=0x008.
REQ-026 Next edge -> word3: rd=4, rs1=0, rs2=0, imm=0xFFF; edges 4..63 -> all outputs 0 (nop).
REQ-027 64 edges after release -> PC wraps to 0x00, outputs again equal word0 values.
REQ-028 Assert rst while PC=0x28 for one edge -> next cycle word0 values; sequence then repeats exactly as REQ-025.
REQ-029 Run 100 cycles free, compare every cycle against a reference model of REQ-011..016 -> zero mismatches.
